// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_DIV_WAIT = 2'd2
    } hz_state_t;

    localparam int DIV_CYCLES_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_controller_stall_timer.sv
// Loadable down-counter shared by multi-cycle stalls and divide waits.
module stall_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_count = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage interlock: load-use and branch stalls, redirect flush, divide wait.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_branch,
    input  logic       id_redirect,
    input  logic       id_div,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       mem_load,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       div_start,
    output logic       div_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    hz_state_t     r_state;
    hz_state_t     w_next;
    logic          r_rst_q;
    logic          w_act;
    logic          w_m_ex;
    logic          w_m_mem;
    logic          w_load_use;
    logic          w_br_ex;
    logic          w_br_mem;
    logic          w_hazard;
    logic          w_two;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_dec;
    logic [CW-1:0] w_count;
    logic          w_zero;

    function automatic logic src_match(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return uses && (rs != 5'd0) && (rs == rd);
    endfunction

    assign w_m_ex = id_valid &&
        (src_match(id_uses_rs1, id_rs1, ex_rd) ||
         src_match(id_uses_rs2, id_rs2, ex_rd));
    assign w_m_mem = id_valid &&
        (src_match(id_uses_rs1, id_rs1, mem_rd) ||
         src_match(id_uses_rs2, id_rs2, mem_rd));

    assign w_load_use = w_m_ex && ex_load;
    assign w_br_ex    = id_branch && w_m_ex && ex_reg_write;
    assign w_br_mem   = id_branch && w_m_mem && mem_load && mem_reg_write;
    assign w_hazard   = w_load_use || w_br_ex || w_br_mem;
    assign w_two      = w_br_ex && ex_load;

    // Outputs stay quiet for the reset cycle and the one after it.
    assign w_act = !rst && !r_rst_q;

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        div_start   = 1'b0;
        div_busy    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        w_next      = r_state;
        if (w_act) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        if (w_two) begin
                            w_load     = 1'b1;
                            w_load_val = CW'(1);
                            w_next     = ST_STALL;
                        end
                    end else begin
                        ifid_flush = id_valid && id_redirect;
                        if (id_valid && id_div) begin
                            div_start  = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = CW'(DIV_CYCLES - 1);
                            w_next     = ST_DIV_WAIT;
                        end
                    end
                end
                ST_STALL: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    w_dec       = 1'b1;
                    if (w_count <= CW'(1)) begin
                        w_next = ST_RUN;
                    end
                end
                ST_DIV_WAIT: begin
                    div_busy   = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    w_dec      = 1'b1;
                    if (w_zero) begin
                        w_next = ST_RUN;
                    end
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    stall_timer #(
        .CW(CW)
    ) u_timer (
        .clk       (clk),
        .i_clr     (rst),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .i_dec     (w_dec),
        .o_count   (w_count),
        .o_zero    (w_zero)
    );

endmodule
